// File: rtl/load_store_unit_if.sv
// Core/memory bundle for the load/store unit.
// slave: LSU side. master: core plus data memory side.
interface load_store_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic                  req;
    logic                  we;
    logic [2:0]            funct3;
    logic [DATA_W-1:0]     addr_in;
    logic [DATA_W-1:0]     store_data;
    logic [DATA_W-1:0]     load_data;
    logic                  done;
    logic                  stall;
    logic                  misalign;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  req, we, funct3, addr_in, store_data, mem_rdata,
        output load_data, done, stall, misalign,
        output mem_rd, mem_wr, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req, we, funct3, addr_in, store_data, mem_rdata,
        input  load_data, done, stall, misalign,
        input  mem_rd, mem_wr, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Handshaked multi-cycle load/store unit between core and data memory.
// Ports: clk, reset (async, active high), bus (load_store_unit_if.slave).
module load_store_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    load_store_unit_if.slave      bus
);
    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam logic [3:0] WAIT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [OFF-1:0]      off_q, off_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NB-1:0]       be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                fault_q, fault_d;
    logic [DATA_W-1:0]   ld_q, ld_d;

    logic [OFF-1:0]      off;
    logic [ADDR_W-1:0]   waddr;
    logic [1:0]          sl_in;
    logic                legal;
    logic [2:0]          am3;
    logic                fault;
    logic [7:0]          bm8;
    logic [NB-1:0]       be_in;
    logic [DATA_W-1:0]   wdata_in;
    logic [DATA_W-1:0]   shifted;
    logic                sgn;
    logic [DATA_W-1:0]   ext;
    logic                unused_hi;

    assign off       = bus.addr_in[OFF-1:0];
    assign waddr     = bus.addr_in[ADDR_W+OFF-1:OFF];
    assign sl_in     = bus.funct3[1:0];
    assign unused_hi = ^bus.addr_in[DATA_W-1:ADDR_W+OFF];

    // Request decode: legality, alignment, lanes and replicated data.
    always_comb begin
        int nbytes;
        legal = 1'b0;
        unique case (bus.funct3)
            3'b000, 3'b001, 3'b010,
            3'b100, 3'b101: legal = 1'b1;
            3'b011, 3'b110: legal = (DATA_W == 64);
            default:        legal = 1'b0;
        endcase

        am3 = 3'd0;
        bm8 = 8'h00;
        unique case (sl_in)
            2'd0: begin am3 = 3'd0; bm8 = 8'h01; end
            2'd1: begin am3 = 3'd1; bm8 = 8'h03; end
            2'd2: begin am3 = 3'd3; bm8 = 8'h0F; end
            default: begin am3 = 3'd7; bm8 = 8'hFF; end
        endcase

        fault = !legal || (|(off & am3[OFF-1:0]));
        be_in = NB'(bm8) << off;

        // Lane i repeats byte (i mod size) of the operand.
        nbytes   = int'(1) << sl_in;
        wdata_in = '0;
        for (int i = 0; i < NB; i++) begin
            wdata_in[i*8 +: 8] = bus.store_data[(i % nbytes)*8 +: 8];
        end
    end

    // Load alignment and extension from latched size/offset.
    always_comb begin
        int nbits;
        shifted = bus.mem_rdata >> {off_q, 3'b000};
        nbits   = 8 << f3_q[1:0];
        sgn     = 1'b0;
        unique case (f3_q[1:0])
            2'd0:    sgn = shifted[7];
            2'd1:    sgn = shifted[15];
            2'd2:    sgn = shifted[31];
            default: sgn = shifted[DATA_W-1];
        endcase
        sgn = sgn & ~f3_q[2];
        ext = '0;
        for (int b = 0; b < DATA_W; b++) begin
            ext[b] = (b < nbits) ? shifted[b] : sgn;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
        ld_d    = ld_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (fault) begin
                        fault_d = 1'b1;
                        ld_d    = '0;
                        state_d = S_RESP;
                    end else begin
                        fault_d = 1'b0;
                        we_d    = bus.we;
                        f3_d    = bus.funct3;
                        off_d   = off;
                        addr_d  = waddr;
                        be_d    = be_in;
                        wdata_d = wdata_in;
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (WAIT_CYCLES > 0) begin
                    cnt_d   = WAIT_INIT;
                    state_d = S_WAIT;
                end else begin
                    ld_d    = we_q ? '0 : ext;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    ld_d    = we_q ? '0 : ext;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            ld_q    <= ld_d;
        end
    end

    // Strobes decode from state so reset drops them without a clock.
    assign bus.mem_rd    = (state_q == S_ACCESS) && !we_q;
    assign bus.mem_wr    = (state_q == S_ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.load_data = ld_q;
    assign bus.done      = (state_q == S_RESP);
    assign bus.misalign  = (state_q == S_RESP) && fault_q;
    assign bus.stall     = ((state_q == S_IDLE) && bus.req)
                         || (state_q == S_ACCESS)
                         || (state_q == S_WAIT);
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised load/store unit sitting between the core datapath and the data memory. It replaces the single-cycle direct memory strobes with a handshaked, multi-cycle access. Features: configurable memory latency, byte/half/word (and double for 64-bit) sizing, byte-enables, sign/zero extension of loads, and misalignment trapping. The core holds its request while `stall` is high and consumes `load_data` on the `done` pulse.

## Interface
- `DATA_W`, default 32, datapath width; legal values 32 or 64.
- `ADDR_W`, default 9, memory word-address width.
- `WAIT_CYCLES`, default 1, extra memory latency cycles; range 0..15.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  access request from the core; held stable until `stall` falls.
- `we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011 D and 110 WU are legal only when DATA_W=64.
- `addr_in`  in  DATA_W  byte address from the ALU.
- `store_data`  in  DATA_W  store operand, right-aligned.
- `load_data`  out  DATA_W  extended load result.
- `done`  out  1  one-cycle completion pulse.
- `stall`  out  1  core must freeze.
- `misalign`  out  1  one-cycle fault pulse, coincident with `done`.
- `mem_rd`, `mem_wr`  out  1  memory strobes.
- `mem_addr`  out  ADDR_W  word address.
- `mem_be`  out  DATA_W/8  byte enables.
- `mem_wdata`  out  DATA_W  lane-replicated write data.
- `mem_rdata`  in  DATA_W  memory read data.

## Operation
- Geometry: OFF = log2(DATA_W/8).
  - Byte offset: `off` = `addr_in[OFF-1:0]`.
  - Word address: `mem_addr` = `addr_in[ADDR_W+OFF-1:OFF]`.
- Size in bytes: B/BU = 1, H/HU = 2, W/WU = 4, D = 8.
- Fault conditions:
  - Misaligned: `off` is not a multiple of the access size.
  - Illegal: `funct3` is not in the legal set for DATA_W.
  - Both are treated identically as a fault.
- FSM states: IDLE, ACCESS, WAIT, RESP.
  - IDLE, `req`=1, no fault: latch `we`, `funct3`, `off`, `mem_addr`, `mem_be` and `mem_wdata`; go to ACCESS.
  - IDLE, `req`=1, fault: no memory strobe; go to RESP with the fault flag set.
  - IDLE, `req`=0: stay in IDLE.
  - ACCESS: `mem_rd` = !`we` or `mem_wr` = `we` for exactly this cycle. Go to WAIT if WAIT_CYCLES>0, else RESP. Loads with WAIT_CYCLES=0 capture `mem_rdata` at the end of ACCESS.
  - WAIT: a counter runs WAIT_CYCLES-1 down to 0. At 0, loads capture `mem_rdata` and the FSM goes to RESP.
  - RESP: `done`=1 and `misalign`=fault flag. Always return to IDLE. `req` is ignored in RESP because it still belongs to the finishing instruction.
- Stores:
  - `mem_be` = ((1<<size)-1) << `off`.
  - `mem_wdata` = the low size bytes of `store_data`, replicated across all lanes.
- Loads:
  - Shift the captured data right by `off`*8 and take the low size bytes.
  - B, H and W sign-extend; BU, HU and WU zero-extend; D passes through.
  - `load_data` updates only in RESP and holds until the next RESP.
  - A faulting access or a store drives `load_data` = 0.
- `stall` = (IDLE & `req`) | ACCESS | WAIT. It is combinational from `req` in IDLE and deasserted in RESP.

## Timing
- Reset values: `load_data`=0, `done`=0, `stall`=0 (while `req`=0), `misalign`=0, `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0, FSM=IDLE, wait counter=0.
- Reset mid-access aborts immediately. Strobes drop asynchronously, the access is lost, and no `done` is issued.
- Nominal access with `req` first high in cycle 0:
  - Strobe in cycle 1.
  - `done` in cycle 2+WAIT_CYCLES.
  - `stall` high in cycles 0 through 1+WAIT_CYCLES.
- Fault access: `stall` high in cycle 0; `done`+`misalign` in cycle 1; no strobe.
- Throughput: one access per 3+WAIT_CYCLES cycles. Back-to-back `req` is accepted in the cycle after RESP.
- Memory contract:
  - `mem_addr`, `mem_be` and `mem_wdata` are registered and held from ACCESS through RESP.
  - `mem_rdata` must be valid WAIT_CYCLES cycles after the `mem_rd` cycle.

## Test plan
- Store byte (DATA_W=32, WAIT_CYCLES=1): SB `addr_in`=0x0000_0013, `store_data`=0x1234_56AB -> cycle 1 `mem_wr`=1, `mem_addr`=4, `mem_be`=4'b1000, `mem_wdata`=0xABAB_ABAB; `done` in cycle 3.
- Load byte, sign extension: LB at 0x3, `mem_rdata`=0x80FF_1234 -> `load_data`=0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- Load halfword: LH at 0x2, `mem_rdata`=0x80FF_1234 -> 0xFFFF_80FF. LHU -> 0x0000_80FF.
- Misaligned load: LW at 0x6 -> no `mem_rd` at any time; `done`=`misalign`=1 in cycle 1; `load_data`=0.
- Latency: WAIT_CYCLES=3 LW -> `stall` high in cycles 0–4, `done` in cycle 5. Then DATA_W=64 LD at 0x8 -> `mem_be`=8'hFF and full 64-bit `load_data`.
- Reset: assert `reset` during WAIT -> `mem_rd`, `stall` and `done` go to 0 at once and the FSM returns to IDLE. A new SW issued after reset release completes normally.
